// File: rtl/fir_pkg.sv
// Shared constants and FSM state type for the FIR filter output path.
package fir_pkg;
  localparam int unsigned SUM_W    = 32;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned Q_SHIFT  = 15;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT,
    CAPTURE
  } fsm_state_e;
endpackage

// File: rtl/fir_output_stage_if.sv
// Valid/ready sample stream leaving the FIR output stage.
interface fir_output_stage_if
  import fir_pkg::*;
#(
  parameter int unsigned OUT_W = SAMPLE_W
);
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/fir_round_sat.sv
// Combinational round-half-up, arithmetic shift and clamp of a signed sum.
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int unsigned IN_W  = SUM_W,
  parameter int unsigned OUT_W = SAMPLE_W,
  parameter int unsigned SHIFT = Q_SHIFT
) (
  input  logic [IN_W-1:0]  sum_i,
  output logic [OUT_W-1:0] sample_o,
  output logic             sat_o
);
  localparam logic signed [IN_W:0] RND   = (IN_W+1)'(1) << (SHIFT - 1);
  localparam logic signed [IN_W:0] MAX_V = (IN_W+1)'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [IN_W:0] MIN_V = ~MAX_V;

  logic signed [IN_W:0] ext;
  logic signed [IN_W:0] rnd;
  logic signed [IN_W:0] shr;

  // One guard bit keeps the rounding add from overflowing at the positive limit.
  always_comb begin
    ext      = signed'({sum_i[IN_W-1], sum_i});
    rnd      = ext + RND;
    shr      = rnd >>> SHIFT;
    sat_o    = 1'b0;
    sample_o = shr[OUT_W-1:0];
    if (shr > MAX_V) begin
      sat_o    = 1'b1;
      sample_o = MAX_V[OUT_W-1:0];
    end else if (shr < MIN_V) begin
      sat_o    = 1'b1;
      sample_o = MIN_V[OUT_W-1:0];
    end
  end
endmodule

// File: rtl/fir_output_stage.sv
// Pops sums from the FIR core queue, scales/saturates them and streams samples
// through a 2-entry buffer while tracking saturation statistics.
module fir_output_stage
  import fir_pkg::*;
#(
  parameter int unsigned IN_W   = SUM_W,
  parameter int unsigned OUT_W  = SAMPLE_W,
  parameter int unsigned SHIFT  = Q_SHIFT,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                clk2,
  input  logic                reset,
  input  logic                empty,
  input  logic [IN_W-1:0]     sum,
  output logic                read,
  fir_output_stage_if.master  out,
  output logic                sat_flag,
  output logic [15:0]         sat_count,
  input  logic                clear_stats
);
  fsm_state_e       state_q, state_d;
  logic [1:0]       wait_q, wait_d;
  logic [1:0]       occ_q, occ_d;
  logic [OUT_W-1:0] head_q, head_d;
  logic [OUT_W-1:0] tail_q, tail_d;
  logic             sat_flag_q, sat_flag_d;
  logic [15:0]      sat_count_q, sat_count_d;

  logic             capture;
  logic             push;
  logic             pop;
  logic             sat_ev;
  logic [OUT_W-1:0] sample;
  logic             sample_sat;

  fir_round_sat #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .SHIFT(SHIFT)
  ) u_round_sat (
    .sum_i   (sum),
    .sample_o(sample),
    .sat_o   (sample_sat)
  );

  // In IDLE nothing is in flight, so buffer occupancy alone bounds the next request.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    read    = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE: if (!empty && (occ_q < 2'd2)) state_d = READ;
      READ: begin
        read = 1'b1;
        if (RD_LAT == 1) begin
          state_d = CAPTURE;
        end else begin
          state_d = WAIT;
          wait_d  = 2'(RD_LAT - 2);
        end
      end
      WAIT: begin
        if (wait_q == 2'd0) state_d = CAPTURE;
        else                wait_d  = wait_q - 2'd1;
      end
      CAPTURE: begin
        capture = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Head-at-slot-0 FIFO: a pop shifts the tail forward, a push fills the next free slot.
  always_comb begin
    push   = capture;
    pop    = (occ_q != 2'd0) && out.out_ready;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (push && pop) begin
      if (occ_q == 2'd2) begin
        head_d = tail_q;
        tail_d = sample;
      end else begin
        head_d = sample;
      end
    end else if (push) begin
      if (occ_q == 2'd0) head_d = sample;
      else               tail_d = sample;
      occ_d = occ_q + 2'd1;
    end else if (pop) begin
      head_d = tail_q;
      occ_d  = occ_q - 2'd1;
    end
  end

  always_comb begin
    sat_ev      = capture && sample_sat;
    sat_flag_d  = sat_flag_q;
    sat_count_d = sat_count_q;
    if (clear_stats) begin
      sat_flag_d  = sat_ev;
      sat_count_d = {15'd0, sat_ev};
    end else if (sat_ev) begin
      sat_flag_d = 1'b1;
      if (sat_count_q != '1) sat_count_d = sat_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk2 or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      occ_q       <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      sat_flag_q  <= 1'b0;
      sat_count_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      occ_q       <= occ_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      sat_flag_q  <= sat_flag_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign out.out_valid = (occ_q != 2'd0);
  assign out.out_data  = head_q;
  assign sat_flag      = sat_flag_q;
  assign sat_count     = sat_count_q;
endmodule

// File: tb/tb_fir_output_stage.sv
// Directed bench for fir_output_stage with a behavioural core-queue model.
module tb_fir_output_stage;
  import fir_pkg::*;

  localparam int unsigned TB_RD_LAT = 2;

  logic        clk2 = 1'b0;
  logic        reset = 1'b0;
  logic        empty;
  logic [31:0] sum;
  logic        read;
  logic        sat_flag;
  logic [15:0] sat_count;
  logic        clear_stats = 1'b0;

  fir_output_stage_if #(.OUT_W(16)) out_if ();

  fir_output_stage #(
    .IN_W  (32),
    .OUT_W (16),
    .SHIFT (15),
    .RD_LAT(TB_RD_LAT)
  ) dut (
    .clk2       (clk2),
    .reset      (reset),
    .empty      (empty),
    .sum        (sum),
    .read       (read),
    .out        (out_if),
    .sat_flag   (sat_flag),
    .sat_count  (sat_count),
    .clear_stats(clear_stats)
  );

  always #5 clk2 = ~clk2;

  // Core queue model: sum appears TB_RD_LAT cycles after the read pulse.
  logic [31:0] mem [0:63];
  int unsigned wr_idx = 0;
  int unsigned rd_idx = 0;
  logic [31:0] pipe [TB_RD_LAT];

  assign empty = (rd_idx == wr_idx);
  assign sum   = pipe[TB_RD_LAT-1];

  always @(posedge clk2) begin
    if (read) begin
      pipe[0] <= mem[rd_idx[5:0]];
      rd_idx  <= rd_idx + 1;
    end
    for (int i = 1; i < TB_RD_LAT; i++) pipe[i] <= pipe[i-1];
  end

  // Protocol monitor, sampled on the falling edge.
  int   cyc = 0, rd_pulses = 0, viol = 0, valid_cycles = 0, rx_cnt = 0;
  int   last_read_cyc = 0, lat = -1;
  int   rx [0:31];
  int   rx_cyc [0:31];
  int   rd_cyc [0:31];
  logic prev_read = 1'b0, prev_valid = 1'b0, prev_hold = 1'b0;
  logic [15:0] prev_data = '0;

  always @(negedge clk2) begin
    cyc++;
    if (read) begin
      if (prev_read) viol++;
      if (empty) viol++;
      rd_cyc[rd_pulses] = cyc;
      last_read_cyc = cyc;
      rd_pulses++;
    end
    if (out_if.out_valid) valid_cycles++;
    if (out_if.out_valid && !prev_valid) lat = cyc - last_read_cyc;
    if (prev_hold && out_if.out_valid && (out_if.out_data != prev_data)) viol++;
    if (out_if.out_valid && out_if.out_ready) begin
      rx[rx_cnt]     = $signed(out_if.out_data);
      rx_cyc[rx_cnt] = cyc;
      rx_cnt++;
    end
    prev_hold  = out_if.out_valid && !out_if.out_ready;
    prev_data  = out_if.out_data;
    prev_read  = read;
    prev_valid = out_if.out_valid;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk2);
    #1;
  endtask

  task automatic push_sum(input logic [31:0] v);
    mem[wr_idx[5:0]] = v;
    wr_idx++;
  endtask

  task automatic wait_rx(input int n, input string tag);
    int c = 0;
    while ((rx_cnt < n) && (c < 200)) begin
      tick();
      c++;
    end
    check_eq(tag, rx_cnt, n);
  endtask

  task automatic wait_read(input string tag);
    int c = 0;
    while ((read !== 1'b1) && (c < 200)) begin
      tick();
      c++;
    end
    check_eq(tag, read, 1);
  endtask

  initial begin
    out_if.out_ready = 1'b0;
    repeat (3) tick();
    check_eq("rst_read", read, 0);
    check_eq("rst_valid", out_if.out_valid, 0);
    check_eq("rst_data", out_if.out_data, 0);
    check_eq("rst_sat_flag", sat_flag, 0);
    check_eq("rst_sat_count", sat_count, 0);
    reset = 1'b1;
    tick();

    // Basic scale
    out_if.out_ready = 1'b1;
    push_sum(32'd32768000);
    wait_rx(1, "t1_rx_count");
    repeat (4) tick();
    check_eq("t1_data", rx[0], 1000);
    check_eq("t1_sat_flag", sat_flag, 0);
    check_eq("t1_read_pulses", rd_pulses, 1);
    check_eq("t1_valid_cycles", valid_cycles, 1);
    check_eq("t1_read_to_valid", lat, TB_RD_LAT + 1);

    // Rounding
    push_sum(32'h0000_4000);
    push_sum(32'hFFFF_C000);
    push_sum(32'h0000_3FFF);
    wait_rx(4, "t2_rx_count");
    check_eq("t2_half_up", rx[1], 1);
    check_eq("t2_neg_half", rx[2], 0);
    check_eq("t2_below_half", rx[3], 0);
    check_eq("t2_sat_count", sat_count, 0);

    // Saturation and stats clear
    push_sum(32'h7FFF_FFFF);
    push_sum(32'h8000_0000);
    wait_rx(6, "t3_rx_count");
    check_eq("t3_pos_clamp", rx[4], 32767);
    check_eq("t3_neg_clamp", rx[5], -32768);
    check_eq("t3_sat_flag", sat_flag, 1);
    check_eq("t3_sat_count", sat_count, 2);
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    check_eq("t3_clr_count", sat_count, 0);
    check_eq("t3_clr_flag", sat_flag, 0);

    // Backpressure
    out_if.out_ready = 1'b0;
    push_sum(32'd1 << 15);
    push_sum(32'd2 << 15);
    push_sum(32'd3 << 15);
    repeat (30) tick();
    check_eq("t4_reads_blocked", rd_pulses - 6, 2);
    check_eq("t4_valid", out_if.out_valid, 1);
    check_eq("t4_head", out_if.out_data, 1);
    check_eq("t4_protocol", viol, 0);
    out_if.out_ready = 1'b1;
    wait_rx(9, "t4_rx_count");
    repeat (3) tick();
    check_eq("t4_first", rx[6], 1);
    check_eq("t4_second", rx[7], 2);
    check_eq("t4_third", rx[8], 3);
    check_eq("t4_read_total", rd_pulses, 9);
    check_eq("t4_read_after_pop", (rd_cyc[8] > rx_cyc[6]) ? 1 : 0, 1);

    // Reset while a request is in flight
    push_sum(32'h7FFF_FFFF);
    wait_rx(10, "t5_rx_count");
    tick();
    check_eq("t5_pre_count", sat_count, 1);
    push_sum(32'd5 << 15);
    wait_read("t5_read_seen");
    tick();
    reset = 1'b0;
    #1;
    check_eq("t5_rst_read", read, 0);
    check_eq("t5_rst_valid", out_if.out_valid, 0);
    check_eq("t5_rst_count", sat_count, 0);
    check_eq("t5_rst_flag", sat_flag, 0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (10) tick();
    check_eq("t5_no_output", rx_cnt, 10);
    check_eq("t5_no_read", rd_pulses, 11);
    push_sum(32'd7 << 15);
    wait_rx(11, "t5_resume_count");
    check_eq("t5_resume_data", rx[10], 7);

    // Stats rollover: preload near the limit rather than stream 65k samples
    force dut.sat_count_q = 16'hFFFD;
    tick();
    release dut.sat_count_q;
    tick();
    check_eq("t6_preload", sat_count, 16'hFFFD);
    push_sum(32'h7FFF_FFFF);
    push_sum(32'h7FFF_FFFF);
    push_sum(32'h7FFF_FFFF);
    wait_rx(14, "t6_rx_count");
    tick();
    check_eq("t6_hold_max", sat_count, 16'hFFFF);
    check_eq("t6_data", rx[13], 32767);
    push_sum(32'h8000_0000);
    wait_read("t6_read_seen");
    repeat (TB_RD_LAT) tick();
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    check_eq("t6_clr_coincident_count", sat_count, 1);
    check_eq("t6_clr_coincident_flag", sat_flag, 1);
    wait_rx(15, "t6_final_count");
    check_eq("t6_final_data", rx[14], -32768);
    check_eq("protocol_final", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
